// File: rtl/msg_sched_pkg.sv
// Shared types and constants for the message send scheduler.
package msg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SENDING
  } sched_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned CNT_W                  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap-around.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    logic            found;
    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(ptr) + off) % N;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/msg_send_scheduler.sv
// Round-robin message send scheduler with response tracking.
// Optional per-slot response timeout enabled by defining MSG_SCHED_TIMEOUT_EN.
module msg_send_scheduler
  import msg_sched_pkg::*;
#(
  parameter int unsigned NUM_MSGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int unsigned ID_W          = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_MSGS-1:0] pending,
  output logic                tx_valid,
  output logic [ID_W-1:0]     tx_id,
  input  logic                tx_ready,
  input  logic                tx_done,
  input  logic                resp_valid,
  input  logic [ID_W-1:0]     resp_id,
  output logic [NUM_MSGS-1:0] sent,
  output logic [NUM_MSGS-1:0] completed,
  output logic [NUM_MSGS-1:0] timed_out,
  output logic [NUM_MSGS-1:0] waiting,
  output logic                busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  sched_state_e        state_q, state_d;
  logic [ID_W-1:0]     tx_id_q, tx_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_MSGS-1:0] waiting_q, waiting_d;
  logic [NUM_MSGS-1:0] sent_q, sent_d;
  logic [NUM_MSGS-1:0] completed_q, completed_d;
  logic [NUM_MSGS-1:0] timed_out_q, timed_out_d;
  logic [NUM_MSGS-1:0] eligible, grant;
  logic [ID_W-1:0]     grant_idx;

`ifdef MSG_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [NUM_MSGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign eligible = pending & ~waiting_q;

  rr_arbiter #(
    .N    (NUM_MSGS),
    .ID_W (ID_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    tx_id_d     = tx_id_q;
    rr_ptr_d    = rr_ptr_q;
    waiting_d   = waiting_q;
    sent_d      = '0;
    completed_d = '0;
    timed_out_d = '0;
`ifdef MSG_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    for (int unsigned i = 0; i < NUM_MSGS; i++) begin
      if (resp_valid && resp_id == ID_W'(i) && waiting_q[i]) begin
        waiting_d[i]   = 1'b0;
        completed_d[i] = 1'b1;
      end
    end

`ifdef MSG_SCHED_TIMEOUT_EN
    // A response landing in the expiry cycle has already claimed the slot above.
    for (int unsigned i = 0; i < NUM_MSGS; i++) begin
      if (!waiting_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TO_LAST) begin
        cnt_d[i] = '0;
        if (!completed_d[i]) begin
          waiting_d[i]   = 1'b0;
          timed_out_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (|grant) begin
          tx_id_d  = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_MSGS - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready) state_d = SENDING;
      end
      SENDING: begin
        if (tx_done) begin
          state_d = IDLE;
          for (int unsigned i = 0; i < NUM_MSGS; i++) begin
            if (tx_id_q == ID_W'(i)) begin
              sent_d[i]    = 1'b1;
              waiting_d[i] = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_id_q     <= '0;
      rr_ptr_q    <= '0;
      waiting_q   <= '0;
      sent_q      <= '0;
      completed_q <= '0;
      timed_out_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_id_q     <= tx_id_d;
      rr_ptr_q    <= rr_ptr_d;
      waiting_q   <= waiting_d;
      sent_q      <= sent_d;
      completed_q <= completed_d;
      timed_out_q <= timed_out_d;
    end
  end

`ifdef MSG_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign tx_valid  = (state_q == ISSUE);
  assign tx_id     = tx_id_q;
  assign busy      = (state_q != IDLE);
  assign waiting   = waiting_q;
  assign sent      = sent_q;
  assign completed = completed_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_msg_send_scheduler.sv
// Self-checking bench for msg_send_scheduler; issue order and sent pulses tracked by scoreboard queues.
module tb_msg_send_scheduler;

  localparam int NM  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  pending;
  logic           tx_valid;
  logic [IDW-1:0] tx_id;
  logic           tx_ready;
  logic           tx_done;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [NM-1:0]  sent, completed, timed_out, waiting;
  logic           busy;

  always #5 clk = ~clk;

  msg_send_scheduler #(
    .NUM_MSGS       (NM),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pending    (pending),
    .tx_valid   (tx_valid),
    .tx_id      (tx_id),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .sent       (sent),
    .completed  (completed),
    .timed_out  (timed_out),
    .waiting    (waiting),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_tx_q[$];
  int exp_sent_q[$];
  bit mon_en = 1'b0;
  int mon_e;

  // Scoreboard: every acceptance and every sent pulse must match the next expected slot.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL issue_order: unexpected acceptance tx_id=%0d, none expected", tx_id);
        end else begin
          mon_e = exp_tx_q.pop_front();
          if (tx_id !== IDW'(mon_e)) begin
            errors++;
            $display("FAIL issue_order: tx_id=%0d, expected %0d", tx_id, mon_e);
          end
        end
      end
      if (sent !== '0) begin
        checks++;
        if (exp_sent_q.size() == 0) begin
          errors++;
          $display("FAIL sent_pulse: unexpected sent=%b, none expected", sent);
        end else begin
          mon_e = exp_sent_q.pop_front();
          if (sent !== NM'(1 << mon_e)) begin
            errors++;
            $display("FAIL sent_pulse: sent=%b, expected slot %0d", sent, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input int id);
    resp_valid = 1'b1;
    resp_id    = IDW'(id);
    tick();
    resp_valid = 1'b0;
  endtask

  // Transmitter model: optionally stalls tx_ready, then completes with optional concurrent response.
  task automatic serve(input int low_cycles, input bit resp_en, input int resp_slot);
    int n;
    logic [IDW-1:0] id0;
    tx_ready = (low_cycles == 0);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tx_valid) begin
      errors++;
      $display("FAIL serve_wait: tx_valid=0 after %0d cycles, required 1", n);
      tx_ready = 1'b0;
      return;
    end
    id0 = tx_id;
    for (int k = 0; k < low_cycles; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_id !== id0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d tx_valid=%b tx_id=%0d, required 1/%0d", k, tx_valid, tx_id, id0);
      end
    end
    if (low_cycles > 0) begin
      tick();
      tx_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL sending_state: busy=%b tx_valid=%b, required 1/0", busy, tx_valid);
    end
    tx_done    = 1'b1;
    resp_valid = resp_en;
    resp_id    = IDW'(resp_slot);
    tick();
    tx_done    = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_id !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b tx_valid=%b tx_id=%0d, required 0/0/0", busy, tx_valid, tx_id);
    end
    checks++;
    if (waiting !== '0 || sent !== '0) begin
      errors++;
      $display("FAIL reset_wait: waiting=%b sent=%b, required 0/0", waiting, sent);
    end
    checks++;
    if (completed !== '0 || timed_out !== '0) begin
      errors++;
      $display("FAIL reset_pulses: completed=%b timed_out=%b, required 0/0", completed, timed_out);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    pending = 4'b0101;
    exp_tx_q.push_back(0);   exp_sent_q.push_back(0);
    exp_tx_q.push_back(2);   exp_sent_q.push_back(2);
    serve(0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || waiting !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b tx_valid=%b waiting=%b, required 0/0/0001", busy, tx_valid, waiting);
    end
    tick();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_id !== 2'd2) begin
      errors++;
      $display("FAIL b2b_latency: tx_valid=%b tx_id=%0d, required 1/2", tx_valid, tx_id);
    end
    tick();
    serve(0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (waiting !== 4'b0101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_final: waiting=%b busy=%b, required 0101/0", waiting, busy);
    end
    pending = '0;
    tick();
  endtask

  task automatic test_response_free();
    respond(0);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0001 || waiting !== 4'b0100) begin
      errors++;
      $display("FAIL resp0: completed=%b waiting=%b, required 0001/0100", completed, waiting);
    end
    tick();
    @(negedge clk);
    checks++;
    if (completed !== '0) begin
      errors++;
      $display("FAIL resp0_width: completed=%b, required 0000", completed);
    end
    tick();
    respond(2);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0100 || waiting !== 4'b0000) begin
      errors++;
      $display("FAIL resp2: completed=%b waiting=%b, required 0100/0000", completed, waiting);
    end
    tick();
  endtask

  task automatic test_rr_wrap();
    pending = 4'b1111;
    exp_tx_q.push_back(3);   exp_sent_q.push_back(3);
    exp_tx_q.push_back(0);   exp_sent_q.push_back(0);
    exp_tx_q.push_back(1);   exp_sent_q.push_back(1);
    exp_tx_q.push_back(2);   exp_sent_q.push_back(2);
    repeat (4) serve(0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (waiting !== 4'b1111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_wrap: waiting=%b busy=%b, required 1111/0", waiting, busy);
    end
    pending = '0;
    tick();
  endtask

  task automatic test_reeligible_stall();
    respond(1);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0010 || waiting !== 4'b1101) begin
      errors++;
      $display("FAIL resp1: completed=%b waiting=%b, required 0010/1101", completed, waiting);
    end
    tick();
    @(negedge clk);
    checks++;
    if (completed !== '0) begin
      errors++;
      $display("FAIL resp1_width: completed=%b, required 0000", completed);
    end
    tick();
    pending = 4'b0010;
    exp_tx_q.push_back(1);   exp_sent_q.push_back(1);
    serve(5, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (waiting !== 4'b1111) begin
      errors++;
      $display("FAIL stall_final: waiting=%b, required 1111", waiting);
    end
    pending = '0;
    tick();
  endtask

  task automatic test_same_cycle();
    respond(0);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0001 || waiting !== 4'b1110) begin
      errors++;
      $display("FAIL same_pre: completed=%b waiting=%b, required 0001/1110", completed, waiting);
    end
    tick();
    pending = 4'b0001;
    exp_tx_q.push_back(0);   exp_sent_q.push_back(0);
    serve(0, 1'b1, 3);
    @(negedge clk);
    checks++;
    if (completed !== 4'b1000 || waiting !== 4'b0111) begin
      errors++;
      $display("FAIL same_cycle: completed=%b waiting=%b, required 1000/0111", completed, waiting);
    end
    pending = '0;
    tick();
  endtask

  task automatic test_same_slot();
    pending = 4'b1000;
    exp_tx_q.push_back(3);   exp_sent_q.push_back(3);
    serve(0, 1'b1, 3);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0000 || waiting !== 4'b1111) begin
      errors++;
      $display("FAIL same_slot: completed=%b waiting=%b, required 0000/1111", completed, waiting);
    end
    pending = '0;
    tick();
  endtask

  task automatic test_bad_resp();
    respond(0);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0001 || waiting !== 4'b1110) begin
      errors++;
      $display("FAIL bad_pre: completed=%b waiting=%b, required 0001/1110", completed, waiting);
    end
    tick();
    respond(0);
    @(negedge clk);
    checks++;
    if (completed !== 4'b0000 || waiting !== 4'b1110 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_resp: completed=%b waiting=%b busy=%b, required 0000/1110/0", completed, waiting, busy);
    end
    tick();
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (timed_out !== '0) bad++;
    end
    checks++;
    if (bad != 0 || waiting !== 4'b1110) begin
      errors++;
      $display("FAIL no_timeout: timed_out seen %0d cycles, waiting=%b, required 0/1110", bad, waiting);
    end
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    pending = 4'b1000;
    exp_tx_q.push_back(3);   exp_sent_q.push_back(3);
    serve(0, 1'b0, 0);
    pending = '0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (timed_out !== '0 || waiting[3] !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d bad cycles before expiry, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (timed_out !== 4'b1000 || waiting !== 4'b0000 || completed !== '0) begin
      errors++;
      $display("FAIL timeout_fire: timed_out=%b waiting=%b completed=%b, required 1000/0000/0000", timed_out, waiting, completed);
    end
    tick();
    @(negedge clk);
    checks++;
    if (timed_out !== '0) begin
      errors++;
      $display("FAIL timeout_width: timed_out=%b, required 0000", timed_out);
    end
    tick();
    pending = 4'b1000;
    exp_tx_q.push_back(3);   exp_sent_q.push_back(3);
    serve(0, 1'b0, 0);
    pending = '0;
    for (int k = 0; k < 9; k++) tick();
    respond(3);
    @(negedge clk);
    checks++;
    if (completed !== 4'b1000 || timed_out !== '0 || waiting !== '0) begin
      errors++;
      $display("FAIL timeout_race: completed=%b timed_out=%b waiting=%b, required 1000/0000/0000", completed, timed_out, waiting);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pending  = 4'b0100;
    tx_ready = 1'b1;
    exp_tx_q.push_back(2);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_id !== 2'd2) begin
      errors++;
      $display("FAIL mid_sending: busy=%b tx_id=%0d, required 1/2", busy, tx_id);
    end
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_id !== '0 || waiting !== '0 ||
        sent !== '0 || completed !== '0 || timed_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b tx_valid=%b tx_id=%0d waiting=%b sent=%b, required all 0",
               busy, tx_valid, tx_id, waiting, sent);
    end
    tick();
    rst     = 1'b0;
    pending = '0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (sent !== '0 || busy !== 1'b0 || waiting !== '0) begin
      errors++;
      $display("FAIL late_done: sent=%b busy=%b waiting=%b, required 0/0/0", sent, busy, waiting);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    pending    = '0;
    tx_ready   = 1'b0;
    tx_done    = 1'b0;
    resp_valid = 1'b0;
    resp_id    = '0;
    test_reset();
    mon_en = 1'b1;
    test_round_robin();
`ifdef MSG_SCHED_TIMEOUT_EN
    test_reset();
    test_timeout();
`else
    test_response_free();
    test_rr_wrap();
    test_reeligible_stall();
    test_same_cycle();
    test_same_slot();
    test_bad_resp();
    test_no_timeout();
`endif
    test_reset_mid();
    checks++;
    if (exp_tx_q.size() != 0 || exp_sent_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d issues and %0d sent pulses outstanding, required 0/0",
               exp_tx_q.size(), exp_sent_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
